channel_display: RTL and testbench

CHANNEL_DISPLAY -- requirements
Module: channel_display

---
 rtl/channel_display.sv | 143 ++++++++++++++
 tb/tb_channel_display.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_display.sv
// ============================================================================
// Module   : channel_display
// Brief    : 8-digit multiplexed 7-segment driver showing "CH-<n>", with a
//            register-bus control/status port and a channel-change indicator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_display #(
    parameter int         REFRESH_DIV = 100000,
    parameter int         HOLD_CYCLES = 50000000,
    parameter logic [3:0] ADDR_CTRL   = 4'hC,
    parameter logic [3:0] ADDR_STAT   = 4'hD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] channel,
    input  logic [3:0] address,
    input  logic [3:0] data,
    input  logic       valid,
    output logic       ack,
    output logic [3:0] data_out,
    output logic       data_out_valid,
    output logic [7:0] pos,
    output logic [7:0] segments
);

    localparam int c_REF_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [c_REF_W-1:0]  c_REF_LAST  = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [7:0] c_SEG_BLANK = 8'hFF;
    localparam logic [7:0] c_SEG_C     = 8'hC6;
    localparam logic [7:0] c_SEG_H     = 8'h89;
    localparam logic [7:0] c_SEG_DASH  = 8'hBF;

    logic [c_REF_W-1:0]  r_refresh;
    logic [2:0]          r_index;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_pending;
    logic                r_enable;
    logic                r_valid_q;
    logic                r_armed;
    logic [1:0]          r_chan_q;
    logic [1:0]          r_chan_prev;

    logic                w_change;
    logic                w_req;
    logic                w_ctrl_req;
    logic                w_stat_req;
    logic [7:0]          w_pos;
    logic [7:0]          w_glyph;

    // r_armed blocks a valid level that was already high across reset from
    // being taken as a fresh request once reset releases.
    assign w_change   = (r_chan_q != r_chan_prev);
    assign w_req      = valid & ~r_valid_q & r_armed;
    assign w_ctrl_req = w_req & (address == ADDR_CTRL);
    assign w_stat_req = w_req & (address == ADDR_STAT);

    assign w_pos = ~(8'd1 << r_index);

    always_comb begin
        w_glyph = c_SEG_BLANK;
        case (r_index)
            3'd0: begin
                case (r_chan_q)
                    2'd0:    w_glyph = 8'hC0;
                    2'd1:    w_glyph = 8'hF9;
                    2'd2:    w_glyph = 8'hA4;
                    default: w_glyph = 8'hB0;
                endcase
                if (r_pending) begin
                    w_glyph[7] = 1'b0;
                end
            end
            3'd1:    w_glyph = c_SEG_DASH;
            3'd2:    w_glyph = c_SEG_H;
            3'd3:    w_glyph = c_SEG_C;
            default: w_glyph = c_SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh      <= '0;
            r_index        <= 3'd0;
            r_hold         <= '0;
            r_pending      <= 1'b0;
            r_enable       <= 1'b1;
            r_valid_q      <= 1'b0;
            r_armed        <= ~valid;
            r_chan_q       <= channel;
            r_chan_prev    <= channel;
            ack            <= 1'b0;
            data_out       <= 4'h0;
            data_out_valid <= 1'b0;
            pos            <= 8'hFF;
            segments       <= 8'hFF;
        end else begin
            if (r_refresh == c_REF_LAST) begin
                r_refresh <= '0;
                r_index   <= r_index + 3'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end

            // A new change restarts the window rather than adding to it.
            if (w_change) begin
                r_hold    <= c_HOLD_LOAD;
                r_pending <= 1'b1;
            end else if (r_pending) begin
                if (r_hold == '0) begin
                    r_pending <= 1'b0;
                end else begin
                    r_hold <= r_hold - 1'b1;
                end
            end

            r_valid_q   <= valid;
            r_armed     <= r_armed | ~valid;
            r_chan_prev <= r_chan_q;
            r_chan_q    <= channel;

            if (w_ctrl_req) begin
                r_enable <= data[0];
            end

            ack            <= w_ctrl_req | w_stat_req;
            data_out_valid <= w_stat_req;
            data_out       <= w_stat_req ? {r_enable, r_pending, r_chan_q} : 4'h0;

            // Anode and glyph come from the same index so they always agree.
            pos      <= r_enable ? w_pos   : 8'hFF;
            segments <= r_enable ? w_glyph : 8'hFF;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_channel_display.sv
// ============================================================================
// Module   : tb_channel_display
// Brief    : Directed self-checking bench for channel_display (DIV=4, HOLD=10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_channel_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] channel;
    logic [3:0] address;
    logic [3:0] data;
    logic       valid;
    logic       ack;
    logic [3:0] data_out;
    logic       data_out_valid;
    logic [7:0] pos;
    logic [7:0] segments;

    int cyc = 0;
    int r_cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    channel_display #(
        .REFRESH_DIV(4),
        .HOLD_CYCLES(10),
        .ADDR_CTRL  (4'hC),
        .ADDR_STAT  (4'hD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .channel       (channel),
        .address       (address),
        .data          (data),
        .valid         (valid),
        .ack           (ack),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .pos           (pos),
        .segments      (segments)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive point: just after the active edge that starts cycle n.
    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sample point: falling edge inside cycle n.
    task automatic samp(input int n);
        go(n);
        @(negedge clk);
    endtask

    // Scan index held in cycle j, counted from the last reset release.
    function automatic int idx_at(input int j);
        return ((j - r_cyc) / 4) % 8;
    endfunction

    function automatic logic [7:0] exp_pos(input int k);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << idx_at(k - 1));
    endfunction

    function automatic logic [7:0] exp_seg(input int idx, input logic [1:0] ch, input bit dp);
        logic [7:0] g;
        case (idx)
            0: begin
                case (ch)
                    2'd0:    g = 8'hC0;
                    2'd1:    g = 8'hF9;
                    2'd2:    g = 8'hA4;
                    default: g = 8'hB0;
                endcase
                if (dp) g[7] = 1'b0;
            end
            1:       g = 8'hBF;
            2:       g = 8'h89;
            3:       g = 8'hC6;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    task automatic test_reset();
        rst = 1'b1; channel = 2'd2; address = 4'h0; data = 4'h0; valid = 1'b0;
        go(3);
        rst = 1'b0;
        r_cyc = 3;
        samp(3);
        tests_run++;
        if (pos !== 8'hFF || segments !== 8'hFF || ack !== 1'b0 ||
            data_out !== 4'h0 || data_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: pos=%h seg=%h ack=%b do=%h dov=%b, want FF FF 0 0 0",
                     pos, segments, ack, data_out, data_out_valid);
        end
        for (int n = 0; n < 8; n++) begin
            samp(r_cyc + 1 + 4 * n);
            tests_run++;
            if (pos !== ~(8'd1 << n) || segments !== exp_seg(n, 2'd2, 1'b0)) begin
                tests_failed++;
                $display("FAIL scan_digit%0d: pos=%h seg=%h, want %h %h",
                         n, pos, segments, ~(8'd1 << n), exp_seg(n, 2'd2, 1'b0));
            end
            if (n == 0) begin
                samp(r_cyc + 4);
                tests_run++;
                if (pos !== 8'hFE) begin
                    tests_failed++;
                    $display("FAIL scan_hold_digit0: pos=%h, want FE", pos);
                end
            end
        end
    endtask

    task automatic test_dp();
        logic [7:0] want [4];
        // Plain 2->3 change; window closes two cycles into a digit-0 slot.
        go(89);
        channel = 2'd3;
        want = '{8'h30, 8'h30, 8'hB0, 8'hB0};
        for (int i = 0; i < 4; i++) begin
            samp(100 + i);
            tests_run++;
            if (pos !== 8'hFE || segments !== want[i]) begin
                tests_failed++;
                $display("FAIL dp_window c%0d: pos=%h seg=%h, want FE %h", 100 + i, pos, segments, want[i]);
            end
        end
        // Second change five cycles into the window must restart it.
        go(148);
        channel = 2'd2;
        go(153);
        channel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            samp(164 + i);
            tests_run++;
            if (pos !== 8'hFE || segments !== want[i]) begin
                tests_failed++;
                $display("FAIL dp_restart c%0d: pos=%h seg=%h, want FE %h", 164 + i, pos, segments, want[i]);
            end
        end
        // Change just before a digit-0 slot: dp appears mid-slot.
        go(195);
        channel = 2'd2;
        want = '{8'hB0, 8'hA4, 8'h24, 8'h24};
        for (int i = 0; i < 4; i++) begin
            samp(196 + i);
            tests_run++;
            if (pos !== 8'hFE || segments !== want[i]) begin
                tests_failed++;
                $display("FAIL dp_start c%0d: pos=%h seg=%h, want FE %h", 196 + i, pos, segments, want[i]);
            end
        end
    endtask

    task automatic test_write();
        go(210);
        address = 4'hC; data = 4'h0; valid = 1'b1;
        samp(210);
        tests_run++;
        if (ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL ctrl_early_ack: ack=%b, want 0", ack);
        end
        for (int k = 211; k <= 218; k++) begin
            if (k == 215) begin
                go(215);
                valid = 1'b0;
            end
            samp(k);
            tests_run++;
            if (ack !== (k == 211) || data_out_valid !== 1'b0 || data_out !== 4'h0) begin
                tests_failed++;
                $display("FAIL ctrl_single_ack c%0d: ack=%b dov=%b do=%h, want %b 0 0",
                         k, ack, data_out_valid, data_out, k == 211);
            end
            if (k == 212 || k == 218) begin
                tests_run++;
                if (pos !== 8'hFF || segments !== 8'hFF) begin
                    tests_failed++;
                    $display("FAIL disabled_blank c%0d: pos=%h seg=%h, want FF FF", k, pos, segments);
                end
            end
        end
        // Re-enable together with a channel change.
        go(220);
        data = 4'h1; valid = 1'b1; channel = 2'd1;
        samp(221);
        tests_run++;
        if (pos !== 8'hFF || ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL enable_write c221: pos=%h ack=%b, want FF 1", pos, ack);
        end
        go(222);
        valid = 1'b0;
        samp(222);
        tests_run++;
        if (pos !== exp_pos(222) || segments !== exp_seg(idx_at(221), 2'd1, 1'b0)) begin
            tests_failed++;
            $display("FAIL enable_resume: pos=%h seg=%h, want %h %h",
                     pos, segments, exp_pos(222), exp_seg(idx_at(221), 2'd1, 1'b0));
        end
        go(223);
        address = 4'hD; valid = 1'b1;
        samp(224);
        tests_run++;
        if (ack !== 1'b1 || data_out_valid !== 1'b1 || data_out !== 4'b1101) begin
            tests_failed++;
            $display("FAIL stat_pending: ack=%b dov=%b do=%b, want 1 1 1101", ack, data_out_valid, data_out);
        end
        go(225);
        valid = 1'b0;
        samp(225);
        tests_run++;
        if (ack !== 1'b0 || data_out_valid !== 1'b0 || data_out !== 4'h0) begin
            tests_failed++;
            $display("FAIL stat_pending_end: ack=%b dov=%b do=%h, want 0 0 0", ack, data_out_valid, data_out);
        end
    endtask

    task automatic test_read();
        go(240);
        address = 4'hD; valid = 1'b1;
        samp(241);
        tests_run++;
        if (ack !== 1'b1 || data_out_valid !== 1'b1 || data_out !== 4'b1001) begin
            tests_failed++;
            $display("FAIL stat_read: ack=%b dov=%b do=%b, want 1 1 1001", ack, data_out_valid, data_out);
        end
        for (int k = 242; k <= 244; k++) begin
            if (k == 243) begin
                go(243);
                valid = 1'b0;
            end
            samp(k);
            tests_run++;
            if (ack !== 1'b0 || data_out_valid !== 1'b0 || data_out !== 4'h0) begin
                tests_failed++;
                $display("FAIL stat_read_end c%0d: ack=%b dov=%b do=%h, want 0 0 0",
                         k, ack, data_out_valid, data_out);
            end
        end
    endtask

    task automatic test_bad_addr();
        go(250);
        address = 4'h7; data = 4'h0; valid = 1'b1;
        for (int k = 251; k <= 253; k++) begin
            if (k == 252) begin
                go(252);
                valid = 1'b0;
            end
            samp(k);
            tests_run++;
            if (ack !== 1'b0 || data_out_valid !== 1'b0 || data_out !== 4'h0) begin
                tests_failed++;
                $display("FAIL foreign_addr c%0d: ack=%b dov=%b do=%h, want 0 0 0",
                         k, ack, data_out_valid, data_out);
            end
        end
        samp(254);
        tests_run++;
        if (pos !== exp_pos(254) || segments !== exp_seg(idx_at(253), 2'd1, 1'b0)) begin
            tests_failed++;
            $display("FAIL foreign_addr_display: pos=%h seg=%h, want %h %h",
                     pos, segments, exp_pos(254), exp_seg(idx_at(253), 2'd1, 1'b0));
        end
    endtask

    task automatic test_reset_mid_request();
        go(260);
        address = 4'hD; valid = 1'b1; rst = 1'b1;
        samp(261);
        tests_run++;
        if (ack !== 1'b0 || data_out_valid !== 1'b0 || pos !== 8'hFF || segments !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_cancel: ack=%b dov=%b pos=%h seg=%h, want 0 0 FF FF",
                     ack, data_out_valid, pos, segments);
        end
        go(263);
        rst = 1'b0;
        r_cyc = 263;
        for (int k = 263; k <= 268; k++) begin
            samp(k);
            tests_run++;
            if (ack !== 1'b0 || data_out_valid !== 1'b0 || data_out !== 4'h0) begin
                tests_failed++;
                $display("FAIL held_valid_ignored c%0d: ack=%b dov=%b do=%h, want 0 0 0",
                         k, ack, data_out_valid, data_out);
            end
            if (k == 264) begin
                tests_run++;
                if (pos !== 8'hFE || segments !== 8'hF9) begin
                    tests_failed++;
                    $display("FAIL first_digit_after_reset: pos=%h seg=%h, want FE F9", pos, segments);
                end
            end
        end
        go(269);
        valid = 1'b0;
        go(271);
        valid = 1'b1;
        samp(272);
        tests_run++;
        if (ack !== 1'b1 || data_out_valid !== 1'b1 || data_out !== 4'b1001) begin
            tests_failed++;
            $display("FAIL rearmed_read: ack=%b dov=%b do=%b, want 1 1 1001", ack, data_out_valid, data_out);
        end
        go(273);
        valid = 1'b0;
        samp(273);
        tests_run++;
        if (ack !== 1'b0 || data_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rearmed_read_end: ack=%b dov=%b, want 0 0", ack, data_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_dp();
        test_write();
        test_read();
        test_bad_addr();
        test_reset_mid_request();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
